// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the serial receive controller and its line/consumer side.
// data_ready/data_read: data_ready holds while the buffer is unread; a one-cycle data_read acknowledges and clears it.
interface rx_frame_ctrl_if;
  logic       serial_in;
  logic       data_read;
  logic       shift_enable;
  logic       load_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output serial_in, data_read,
    input  shift_enable, load_data, data_ready, framing_error, overrun_error, busy, state_dbg
  );

  modport slave (
    input  serial_in, data_read,
    output shift_enable, load_data, data_ready, framing_error, overrun_error, busy, state_dbg
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Serial frame receive controller: times start/data/stop bits and pulses an external
// shift register and receive buffer; tracks ready, framing and overrun status.
module rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  rx_frame_ctrl_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] B_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START_CHK, DATA, STOP, LOAD} state_t;

  state_t        state, next_state;
  logic          prev_rx;
  logic [TW-1:0] timer;
  logic [CW-1:0] bit_cnt;
  logic          start_edge, timer_done, half_done, enter_data;
  logic          shift_next, load_next;

  assign start_edge = prev_rx & ~bus.serial_in;
  assign timer_done = (timer == T_LAST);
  assign half_done  = (timer == T_HALF);
  assign enter_data = (state == START_CHK) && (next_state == DATA);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_edge) next_state = START_CHK;
      START_CHK: if (half_done) next_state = bus.serial_in ? IDLE : DATA;
      DATA:      if (timer_done && bit_cnt == B_LAST) next_state = STOP;
      STOP:      if (timer_done) next_state = bus.serial_in ? LOAD : IDLE;
      LOAD:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.state_dbg = state;
    shift_next    = (state == DATA) && timer_done;
    load_next     = (next_state == LOAD);
  end

  // Pulses are registered so they align with the state they belong to (load_data with LOAD).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_rx          <= 1'b1;
      timer            <= '0;
      bit_cnt          <= '0;
      bus.shift_enable <= 1'b0;
      bus.load_data    <= 1'b0;
    end else begin
      prev_rx          <= bus.serial_in;
      bus.shift_enable <= shift_next;
      bus.load_data    <= load_next;
      case (state)
        START_CHK:  timer <= half_done ? '0 : timer + 1'b1;
        DATA, STOP: timer <= timer_done ? '0 : timer + 1'b1;
        default:    timer <= '0;
      endcase
      if (enter_data)     bit_cnt <= '0;
      else if (shift_next) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Status flags; a load in the same cycle as data_read leaves data_ready set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.data_ready    <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun_error <= 1'b0;
    end else begin
      if (state == LOAD)     bus.data_ready <= 1'b1;
      else if (bus.data_read) bus.data_ready <= 1'b0;

      if (enter_data) bus.framing_error <= 1'b0;
      else if ((state == STOP) && timer_done && !bus.serial_in) bus.framing_error <= 1'b1;

      if ((state == LOAD) && bus.data_ready && !bus.data_read) bus.overrun_error <= 1'b1;
      else if (bus.data_read) bus.overrun_error <= 1'b0;
    end
  end
endmodule
